// File: rtl/mem_subsystem_arb.sv
// rtl/mem_subsystem_arb.sv - shared single-port word RAM arbitrated between fetch and data ports
// Data port wins by default; a starvation counter forces a fetch grant after STARVE_MAX denials.
module mem_subsystem_arb #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 10,
    parameter int PADDR_W    = 16,
    parameter int STARVE_MAX = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               if_req,
    input  logic [PADDR_W-1:0] if_addr,
    output logic               if_ready,
    output logic               if_valid,
    output logic [DATA_W-1:0]  ir,
    input  logic               dm_req,
    input  logic               dm_we,
    input  logic               memsrc,
    input  logic [PADDR_W-1:0] dm_addr0,
    input  logic [PADDR_W-1:0] dm_addr1,
    input  logic [DATA_W-1:0]  dm_wdata,
    input  logic               dm_imm,
    output logic               dm_ready,
    output logic               dm_valid,
    output logic [DATA_W-1:0]  memout,
    output logic [DATA_W-1:0]  imr
);
    localparam int CNT_W = (STARVE_MAX > 1) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic [CNT_W-1:0]  starve_cnt;
    logic              force_fetch;
    logic              dm_acc;
    logic              if_acc;
    logic [ADDR_W-1:0] dm_index;
    logic [ADDR_W-1:0] ram_index;
    logic [DATA_W-1:0] ram_rdata;
    logic              unused_addr_bits;

    assign force_fetch = (STARVE_MAX != 0) && (starve_cnt == CNT_MAX);
    assign dm_ready    = !force_fetch;
    assign if_ready    = !dm_req || force_fetch;
    assign dm_acc      = dm_req && dm_ready;
    assign if_acc      = if_req && if_ready;

    // Only the low ADDR_W bits index the RAM, so addresses wrap naturally.
    assign dm_index  = memsrc ? dm_addr1[ADDR_W-1:0] : dm_addr0[ADDR_W-1:0];
    assign ram_index = dm_acc ? dm_index : if_addr[ADDR_W-1:0];
    assign ram_rdata = mem[ram_index];
    assign unused_addr_bits = ^{if_addr, dm_addr0, dm_addr1};

    // RAM contents survive reset, but a write accepted on a reset edge is dropped.
    always_ff @(posedge clk) begin
        if (!reset && dm_acc && dm_we) begin
            mem[ram_index] <= dm_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (if_req && !if_ready) begin
            starve_cnt <= (starve_cnt == CNT_MAX) ? starve_cnt : starve_cnt + 1'b1;
        end else begin
            starve_cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            if_valid <= 1'b0;
            dm_valid <= 1'b0;
            ir       <= '0;
            memout   <= '0;
            imr      <= '0;
        end else begin
            if_valid <= if_acc;
            dm_valid <= dm_acc;
            if (if_acc) begin
                ir <= ram_rdata;
            end
            if (dm_acc && !dm_we) begin
                memout <= ram_rdata;
                if (dm_imm) begin
                    imr <= ram_rdata;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_subsystem_arb.sv
// tb/tb_mem_subsystem_arb.sv - scoreboard bench for mem_subsystem_arb
module tb_mem_subsystem_arb;
    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_ready;
    logic        if_valid;
    logic [15:0] ir;
    logic        dm_req;
    logic        dm_we;
    logic        memsrc;
    logic [15:0] dm_addr0;
    logic [15:0] dm_addr1;
    logic [15:0] dm_wdata;
    logic        dm_imm;
    logic        dm_ready;
    logic        dm_valid;
    logic [15:0] memout;
    logic [15:0] imr;

    typedef struct {
        logic [15:0] memout;
        logic [15:0] imr;
    } dm_exp_t;

    dm_exp_t     dm_q[$];
    logic [15:0] if_q[$];
    logic [15:0] model [0:1023];
    logic [15:0] exp_memout;
    logic [15:0] exp_imr;
    int          errors = 0;
    int          checks = 0;

    mem_subsystem_arb #(
        .DATA_W(16), .ADDR_W(10), .PADDR_W(16), .STARVE_MAX(3)
    ) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
        .if_valid(if_valid), .ir(ir),
        .dm_req(dm_req), .dm_we(dm_we), .memsrc(memsrc),
        .dm_addr0(dm_addr0), .dm_addr1(dm_addr1), .dm_wdata(dm_wdata),
        .dm_imm(dm_imm), .dm_ready(dm_ready), .dm_valid(dm_valid),
        .memout(memout), .imr(imr)
    );

    always #5 clk = ~clk;

    // Drives one data request, waits for acceptance, pushes the expected result,
    // and returns at the following negedge (+1) with dm_req dropped.
    task automatic dm_issue(input logic we, input logic sel, input logic [15:0] a0,
                            input logic [15:0] a1, input logic [15:0] wd, input logic imm);
        logic [9:0] idx;
        dm_exp_t    e;
        int         n;
        @(negedge clk);
        dm_req = 1'b1; dm_we = we; memsrc = sel; dm_addr0 = a0; dm_addr1 = a1;
        dm_wdata = wd; dm_imm = imm;
        #1;
        n = 0;
        while (!dm_ready && n < 20) begin
            @(negedge clk); #1; n++;
        end
        checks++;
        if (n == 20) begin
            errors++;
            $display("FAIL dm_accept_timeout: dm_ready=%b required 1", dm_ready);
        end
        idx = sel ? a1[9:0] : a0[9:0];
        if (we) begin
            model[idx] = wd;
        end else begin
            exp_memout = model[idx];
            if (imm) exp_imr = model[idx];
        end
        e.memout = exp_memout;
        e.imr    = exp_imr;
        dm_q.push_back(e);
        @(negedge clk);
        dm_req = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
        memsrc = 1'b0; dm_addr0 = '0; dm_addr1 = '0; dm_wdata = '0; dm_imm = 1'b0;
        exp_memout = '0; exp_imr = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if ({if_valid, dm_valid} !== 2'b00) begin
            errors++; $display("FAIL reset_valids: got %b required 00", {if_valid, dm_valid});
        end
        checks++;
        if ({ir, memout, imr} !== 48'h0) begin
            errors++; $display("FAIL reset_regs: ir=%h memout=%h imr=%h required 0", ir, memout, imr);
        end
        checks++;
        if ({if_ready, dm_ready} !== 2'b11) begin
            errors++; $display("FAIL reset_ready: got %b required 11", {if_ready, dm_ready});
        end
    endtask

    task automatic test_store_load;
        dm_exp_t e;
        dm_issue(1'b1, 1'b0, 16'h0005, 16'h0123, 16'hBEEF, 1'b0);
        e = dm_q.pop_front();
        checks++;
        if (dm_valid !== 1'b1 || memout !== e.memout || imr !== e.imr) begin
            errors++;
            $display("FAIL store_result: valid=%b memout=%h imr=%h required 1 %h %h",
                     dm_valid, memout, imr, e.memout, e.imr);
        end
        dm_issue(1'b0, 1'b1, 16'h0300, 16'h0005, 16'h0000, 1'b1);
        e = dm_q.pop_front();
        checks++;
        if (dm_valid !== 1'b1 || memout !== e.memout || imr !== e.imr) begin
            errors++;
            $display("FAIL load_imm: valid=%b memout=%h imr=%h required 1 %h %h",
                     dm_valid, memout, imr, e.memout, e.imr);
        end
        @(negedge clk); #1;
        checks++;
        if (dm_valid !== 1'b0 || memout !== 16'hBEEF) begin
            errors++; $display("FAIL dm_valid_pulse: valid=%b memout=%h required 0 beef", dm_valid, memout);
        end
    endtask

    task automatic test_imm_hold;
        dm_exp_t e;
        dm_issue(1'b0, 1'b0, 16'h0005, 16'h0000, 16'h0000, 1'b0);
        void'(dm_q.pop_front());
        dm_issue(1'b1, 1'b0, 16'h0006, 16'h0000, 16'h1234, 1'b0);
        void'(dm_q.pop_front());
        dm_issue(1'b0, 1'b0, 16'h0006, 16'h0000, 16'h0000, 1'b0);
        e = dm_q.pop_front();
        checks++;
        if (dm_valid !== 1'b1 || memout !== e.memout || imr !== e.imr) begin
            errors++;
            $display("FAIL imm_hold: valid=%b memout=%h imr=%h required 1 %h %h",
                     dm_valid, memout, imr, e.memout, e.imr);
        end
    endtask

    task automatic test_wrap;
        dm_exp_t    e;
        logic [15:0] exp_ir;
        dm_issue(1'b1, 1'b0, 16'h0005, 16'h0000, 16'hA5A5, 1'b0);
        void'(dm_q.pop_front());
        @(negedge clk);
        if_req = 1'b1; if_addr = 16'h0405;
        #1;
        checks++;
        if (if_ready !== 1'b1) begin
            errors++; $display("FAIL wrap_if_ready: got %b required 1", if_ready);
        end
        if_q.push_back(model[10'h005]);
        @(negedge clk);
        if_req = 1'b0;
        #1;
        exp_ir = if_q.pop_front();
        checks++;
        if (if_valid !== 1'b1 || ir !== exp_ir) begin
            errors++; $display("FAIL fetch_wrap: valid=%b ir=%h required 1 %h", if_valid, ir, exp_ir);
        end
        dm_issue(1'b0, 1'b0, 16'h8405, 16'h0000, 16'h0000, 1'b0);
        e = dm_q.pop_front();
        checks++;
        if (memout !== e.memout) begin
            errors++; $display("FAIL load_wrap: memout=%h required %h", memout, e.memout);
        end
    endtask

    task automatic test_starvation;
        logic [15:0] exp_ir;
        @(negedge clk);
        if_req = 1'b1; if_addr = 16'h0006;
        dm_req = 1'b1; dm_we = 1'b0; memsrc = 1'b0; dm_addr0 = 16'h0005; dm_imm = 1'b0;
        exp_memout = model[10'h005];
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if ({if_ready, dm_ready} !== 2'b01) begin
                errors++; $display("FAIL starve_deny_%0d: if/dm ready=%b required 01", c, {if_ready, dm_ready});
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if ({if_ready, dm_ready} !== 2'b10 || dm_valid !== 1'b1) begin
            errors++;
            $display("FAIL starve_force: if/dm ready=%b dm_valid=%b required 10 1", {if_ready, dm_ready}, dm_valid);
        end
        if_q.push_back(model[10'h006]);
        @(negedge clk);
        if_req = 1'b0;
        #1;
        exp_ir = if_q.pop_front();
        checks++;
        if (if_valid !== 1'b1 || ir !== exp_ir || dm_valid !== 1'b0) begin
            errors++;
            $display("FAIL starve_fetch: if_valid=%b ir=%h dm_valid=%b required 1 %h 0", if_valid, ir, dm_valid, exp_ir);
        end
        checks++;
        if (dm_ready !== 1'b1 || memout !== exp_memout) begin
            errors++; $display("FAIL starve_resume: dm_ready=%b memout=%h required 1 %h", dm_ready, memout, exp_memout);
        end
        @(negedge clk);
        dm_req = 1'b0;
        #1;
    endtask

    task automatic test_reset_mid;
        dm_exp_t e;
        dm_issue(1'b1, 1'b0, 16'h0010, 16'h0000, 16'h2222, 1'b0);
        void'(dm_q.pop_front());
        @(negedge clk);
        dm_req = 1'b1; dm_we = 1'b1; memsrc = 1'b0; dm_addr0 = 16'h0010; dm_wdata = 16'h1111;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; dm_req = 1'b0;
        exp_memout = '0; exp_imr = '0;
        #1;
        checks++;
        if (dm_valid !== 1'b0 || {ir, memout, imr} !== 48'h0) begin
            errors++;
            $display("FAIL reset_mid: dm_valid=%b ir=%h memout=%h imr=%h required 0 0 0 0", dm_valid, ir, memout, imr);
        end
        dm_issue(1'b0, 1'b1, 16'h0000, 16'h0010, 16'h0000, 1'b0);
        e = dm_q.pop_front();
        checks++;
        if (memout !== e.memout) begin
            errors++; $display("FAIL reset_no_write: memout=%h required %h", memout, e.memout);
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] exp_ir;
        for (int i = 0; i < 4; i++) begin
            dm_issue(1'b1, 1'b0, 16'(i), 16'h0000, 16'hC000 + 16'(i * 17), 1'b0);
            void'(dm_q.pop_front());
        end
        @(negedge clk);
        if_req = 1'b1; if_addr = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (if_ready !== 1'b1) begin
                errors++; $display("FAIL b2b_ready_%0d: got %b required 1", i, if_ready);
            end
            if_q.push_back(model[i]);
            @(negedge clk);
            if (i < 3) if_addr = 16'(i + 1);
            else       if_req = 1'b0;
            #1;
            exp_ir = if_q.pop_front();
            checks++;
            if (if_valid !== 1'b1 || ir !== exp_ir) begin
                errors++; $display("FAIL b2b_fetch_%0d: valid=%b ir=%h required 1 %h", i, if_valid, ir, exp_ir);
            end
        end
        @(negedge clk); #1;
        checks++;
        if (if_valid !== 1'b0 || dm_valid !== 1'b0 || ir !== model[3] || memout !== exp_memout) begin
            errors++;
            $display("FAIL idle_hold: if_valid=%b dm_valid=%b ir=%h memout=%h required 0 0 %h %h",
                     if_valid, dm_valid, ir, memout, model[3], exp_memout);
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_imm_hold();
        test_wrap();
        test_starvation();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
